imem_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the single-port imem (32-bit byte address a, read enable IM_R, combinational rd).
//  - Owns the PC and issues one imem read per cycle while buffer space exists.
//  - Captures {pc, instruction} pairs into a prefetch FIFO that decode drains with a valid/ready handshake.
//  - Handles branch/jump redirects (flush plus PC reload) and halt requests. Sits between imem and the decode stage.

---
 rtl/imem_fetch_ctrl_if.sv | 47 ++++
 rtl/imem_fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl_if
//  Description : Bus bundle between the fetch controller, the single-port
//                imem and the decode stage. Carries the imem read port
//                (imem_a / imem_r / imem_rd), the decode handshake
//                (inst_valid / inst_ready / inst / inst_pc), the redirect and
//                halt controls, and the controller status outputs
//                (halted / fifo_count / fetch_err).
//                master : fetch controller side
//                slave  : imem + decode + control side
//  Revision    : 1.0  initial release
// ============================================================================
interface imem_fetch_ctrl_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    // imem read port
    logic [31:0]        imem_a;
    logic               imem_r;
    logic [31:0]        imem_rd;
    // decode handshake
    logic               inst_valid;
    logic               inst_ready;
    logic [31:0]        inst;
    logic [31:0]        inst_pc;
    // control
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               halt_req;
    // status
    logic               halted;
    logic [c_cnt_w-1:0] fifo_count;
    logic               fetch_err;

    modport master (
        output imem_a, imem_r, inst_valid, inst, inst_pc, halted, fifo_count, fetch_err,
        input  imem_rd, inst_ready, redirect_valid, redirect_pc, halt_req
    );

    modport slave (
        input  imem_a, imem_r, inst_valid, inst, inst_pc, halted, fifo_count, fetch_err,
        output imem_rd, inst_ready, redirect_valid, redirect_pc, halt_req
    );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl
//  Description : Instruction-fetch sequencer. Owns the PC, issues one imem
//                read per cycle while the prefetch FIFO has room, and queues
//                {pc, instruction} pairs for decode. Handles redirects
//                (flush + PC reload) and halt requests.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active-high
//                bus  - imem_fetch_ctrl_if.master (imem port, decode
//                       handshake, redirect/halt controls, status)
//  Options     : IMEM_ALIGN_CHK_EN - when defined, a misaligned PC in RUN
//                blocks the fetch, halts the FSM and sets a sticky fetch_err.
//  Revision    : 1.0  initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  wire                 clk,
    input  wire                 rst,
    imem_fetch_ctrl_if.master   bus
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t               r_state;
    logic [31:0]          r_pc;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_halted;
    logic [31:0]          r_fifo_inst [FIFO_DEPTH];
    logic [31:0]          r_fifo_pc   [FIFO_DEPTH];

    logic                 w_full;
    logic                 w_misalign;
    logic                 w_issue;
    logic                 w_valid;
    logic                 w_pop;

`ifdef IMEM_ALIGN_CHK_EN
    logic                 r_fetch_err;
    assign w_misalign = (r_state == S_RUN) && (r_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Fullness uses the registered count, so a pop in a full cycle does not
    // open a slot until the next cycle.
    assign w_full  = (r_count == c_cnt_w'(FIFO_DEPTH));
    assign w_issue = (r_state == S_RUN) && !w_full && !bus.redirect_valid
                     && !bus.halt_req && !w_misalign;
    // A redirect hides the head so no stale instruction is handed to decode.
    assign w_valid = (r_count != '0) && !bus.redirect_valid;
    assign w_pop   = w_valid && bus.inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_PC;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_halted    <= 1'b0;
`ifdef IMEM_ALIGN_CHK_EN
            r_fetch_err <= 1'b0;
`endif
        end else if (bus.redirect_valid) begin
            r_state     <= S_RUN;
            r_pc        <= bus.redirect_pc;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_halted    <= 1'b0;
`ifdef IMEM_ALIGN_CHK_EN
            r_fetch_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_BOOT: r_state <= S_RUN;
                S_RUN: begin
                    if (w_misalign || bus.halt_req) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end
`ifdef IMEM_ALIGN_CHK_EN
                    if (w_misalign) r_fetch_err <= 1'b1;
`endif
                end
                S_HALT: r_state <= S_HALT;
                default: begin
                    r_state  <= S_BOOT;
                    r_halted <= 1'b0;
                end
            endcase

            if (w_issue) begin
                r_pc     <= r_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);

            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_fifo_inst[r_wr_ptr] <= bus.imem_rd;
            r_fifo_pc[r_wr_ptr]   <= r_pc;
        end
    end

    assign bus.imem_a     = r_pc;
    assign bus.imem_r     = w_issue;
    assign bus.inst_valid = w_valid;
    assign bus.inst       = w_valid ? r_fifo_inst[r_rd_ptr] : 32'd0;
    assign bus.inst_pc    = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'd0;
    assign bus.halted     = r_halted;
    assign bus.fifo_count = r_count;
`ifdef IMEM_ALIGN_CHK_EN
    assign bus.fetch_err  = r_fetch_err;
`else
    assign bus.fetch_err  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_fetch_ctrl
//  Description : Directed self-checking bench for imem_fetch_ctrl
//                (FIFO_DEPTH=4, RESET_PC=0). imem is a small address->data
//                function driven combinationally from imem_a.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_issue;

    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.FIFO_DEPTH(4)) bus ();

    imem_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0:   imem_word = 32'h11;
            32'h4:   imem_word = 32'h22;
            32'h8:   imem_word = 32'h33;
            default: imem_word = {a[15:0], 16'hC0DE};
        endcase
    endfunction

    assign bus.imem_rd = imem_word(bus.imem_a);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here and
    // outputs are sampled 1 time unit later, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.halt_req       = 1'b0;
        rst                = 1'b1;
        tick(); tick();
        settle();
        check("rst_count",  64'(bus.fifo_count), 64'd0);
        check("rst_valid",  64'(bus.inst_valid), 64'd0);
        check("rst_imem_r", 64'(bus.imem_r),     64'd0);
        check("rst_halted", 64'(bus.halted),     64'd0);
        check("rst_err",    64'(bus.fetch_err),  64'd0);
        check("rst_pc",     64'(bus.imem_a),     64'd0);

        // ---- 1: BOOT cycle then in-order stream ----
        rst = 1'b0; settle();
        check("boot_no_fetch", 64'(bus.imem_r), 64'd0);
        tick(); settle();
        check("c1_imem_r", 64'(bus.imem_r), 64'd1);
        check("c1_imem_a", 64'(bus.imem_a), 64'h0);
        check("c1_valid",  64'(bus.inst_valid), 64'd0);
        tick(); settle();
        check("c2_pc",   64'(bus.inst_pc), 64'h0);
        check("c2_inst", 64'(bus.inst),    64'h11);
        tick(); settle();
        check("c3_pc",    64'(bus.inst_pc),    64'h4);
        check("c3_inst",  64'(bus.inst),       64'h22);
        check("c3_count", 64'(bus.fifo_count), 64'd1);
        tick(); settle();
        check("c4_pc",   64'(bus.inst_pc), 64'h8);
        check("c4_inst", 64'(bus.inst),    64'h33);

        // ---- 2: fill with decode stalled ----
        rst = 1'b1; bus.inst_ready = 1'b0;
        tick();
        rst = 1'b0;
        n_issue = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (bus.imem_r) n_issue++;
            tick();
        end
        settle();
        check("fill_issues", 64'(n_issue),        64'd4);
        check("fill_count",  64'(bus.fifo_count), 64'd4);
        check("fill_imem_r", 64'(bus.imem_r),     64'd0);
        check("fill_pc",     64'(bus.imem_a),     64'h10);
        check("fill_head",   64'(bus.inst_pc),    64'h0);
        bus.inst_ready = 1'b1; settle();
        check("full_pop_bubble", 64'(bus.imem_r), 64'd0);
        tick(); settle();
        check("after_pop_count", 64'(bus.fifo_count), 64'd3);
        check("after_pop_head",  64'(bus.inst_pc),    64'h4);
        check("resume_imem_r",   64'(bus.imem_r),     64'd1);
        check("resume_imem_a",   64'(bus.imem_a),     64'h10);
        tick(); settle();

        // ---- 3: redirect with 3 entries queued ----
        check("pre_redir_count", 64'(bus.fifo_count), 64'd3);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; settle();
        check("redir_valid_forced0", 64'(bus.inst_valid), 64'd0);
        check("redir_no_fetch",      64'(bus.imem_r),     64'd0);
        tick();
        bus.redirect_valid = 1'b0; settle();
        check("post_redir_count",  64'(bus.fifo_count), 64'd0);
        check("post_redir_valid",  64'(bus.inst_valid), 64'd0);
        check("post_redir_imem_a", 64'(bus.imem_a),     64'h40);
        check("post_redir_imem_r", 64'(bus.imem_r),     64'd1);
        tick(); settle();
        check("redir_first_pc",   64'(bus.inst_pc), 64'h40);
        check("redir_first_inst", 64'(bus.inst),    64'h0040_C0DE);

        // ---- 4: halt with 2 queued, drain, redirect out ----
        bus.inst_ready = 1'b0;
        tick();
        bus.halt_req = 1'b1; settle();
        check("halt_req_blocks", 64'(bus.imem_r), 64'd0);
        tick();
        bus.halt_req = 1'b0; settle();
        check("halted",       64'(bus.halted),     64'd1);
        check("halt_no_fetch",64'(bus.imem_r),     64'd0);
        check("halt_count",   64'(bus.fifo_count), 64'd2);
        check("halt_head",    64'(bus.inst_pc),    64'h40);
        bus.inst_ready = 1'b1;
        tick(); settle();
        check("drain1_pc",    64'(bus.inst_pc),    64'h44);
        check("drain1_count", 64'(bus.fifo_count), 64'd1);
        tick(); settle();
        check("drain2_count", 64'(bus.fifo_count), 64'd0);
        check("drain2_valid", 64'(bus.inst_valid), 64'd0);
        check("still_halted", 64'(bus.halted),     64'd1);
        check("halt_idle_r",  64'(bus.imem_r),     64'd0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
        tick();
        bus.redirect_valid = 1'b0; settle();
        check("unhalt",        64'(bus.halted), 64'd0);
        check("unhalt_imem_r", 64'(bus.imem_r), 64'd1);
        check("unhalt_imem_a", 64'(bus.imem_a), 64'h100);

        // ---- redirect wins over simultaneous halt_req ----
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; bus.halt_req = 1'b1;
        tick();
        bus.redirect_valid = 1'b0; bus.halt_req = 1'b0; settle();
        check("redir_over_halt",   64'(bus.halted), 64'd0);
        check("redir_over_halt_r", 64'(bus.imem_r), 64'd1);
        check("redir_over_halt_a", 64'(bus.imem_a), 64'h200);

        // ---- 5: PC wrap ----
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0; settle();
        check("wrap_issue_a", 64'(bus.imem_a), 64'hFFFF_FFFC);
        check("wrap_issue_r", 64'(bus.imem_r), 64'd1);
        tick(); settle();
        check("wrap_next_a",  64'(bus.imem_a),  64'h0);
        check("wrap_head_pc", 64'(bus.inst_pc), 64'hFFFF_FFFC);

        // ---- reset mid-run, then redirect during BOOT ----
        rst = 1'b1;
        tick();
        rst = 1'b0; settle();
        check("midrst_count", 64'(bus.fifo_count), 64'd0);
        check("midrst_valid", 64'(bus.inst_valid), 64'd0);
        check("midrst_pc",    64'(bus.imem_a),     64'h0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h80;
        tick();
        bus.redirect_valid = 1'b0; settle();
        check("boot_redir_a", 64'(bus.imem_a), 64'h80);
        check("boot_redir_r", 64'(bus.imem_r), 64'd1);
        check("no_err_default_path", 64'(bus.fetch_err), 64'd0);

`ifdef IMEM_ALIGN_CHK_EN
        // ---- 6: misaligned redirect target ----
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h42;
        tick();
        bus.redirect_valid = 1'b0; settle();
        check("mis_no_fetch", 64'(bus.imem_r), 64'd0);
        tick(); settle();
        check("mis_err",      64'(bus.fetch_err), 64'd1);
        check("mis_halted",   64'(bus.halted),    64'd1);
        check("mis_no_fetch2",64'(bus.imem_r),    64'd0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h44;
        tick();
        bus.redirect_valid = 1'b0; settle();
        check("mis_clear_err", 64'(bus.fetch_err), 64'd0);
        check("mis_refetch_r", 64'(bus.imem_r),    64'd1);
        check("mis_refetch_a", 64'(bus.imem_a),    64'h44);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
